operand_bank_loader: RTL
========================

# operand_bank_loader

Memory-response side of the systolic matrix multiplier's operand fetch path. It sits between the ROM (weights) and RAM (activations) read ports and the MAC array. It takes the read strobe, bank select and entry select issued by the controller, and aligns them with memory data that returns with fixed latency. It writes each weight/activation pair into an 8-bank × 8-entry register bank, tracks fill status per bank, and presents a combinational read port to the MAC array.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each weight and activation word
- BANKS, 8, number of register banks
- ENTRIES, 8, entries per bank
- BANK_SEL_W, 4, width of the bank select input
- ENTRY_SEL_W, 3, width of the entry select input
- MEM_LATENCY, 2, cycles from request to valid memory data; legal values are 1 to 4

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rd_en  in  1  controller read strobe; one request per cycle while high
- bank_sel  in  BANK_SEL_W  target bank of the current request
- entry_sel  in  ENTRY_SEL_W  target entry of the current request
- rom_rdata  in  DATA_WIDTH  weight word returned by the ROM
- ram_rdata  in  DATA_WIDTH  activation word returned by the RAM
- clr  in  1  single-cycle pulse that starts a new tile by clearing all fill status
- rd_bank  in  BANK_SEL_W-1  MAC-side read bank
- rd_entry  in  ENTRY_SEL_W  MAC-side read entry
- weight_out  out  DATA_WIDTH  stored weight at (rd_bank, rd_entry)
- act_out  out  DATA_WIDTH  stored activation at (rd_bank, rd_entry)
- bank_full  out  BANKS  bit b is high when all entries of bank b are written since the last clr
- load_done  out  1  registered; high when all bank_full bits are set
- overrun_err  out  1  sticky error flag (see Configuration)

## Operation
- Request tag: {rd_en, bank_sel, entry_sel}, captured every cycle into a delay line of depth MEM_LATENCY.
- Tag exits the delay line with valid=1:
  - If bank_sel < BANKS, write rom_rdata/ram_rdata into storage[bank][entry] and set entry_valid[bank][entry].
  - Otherwise drop the response silently. The controller emits bank_sel = BANKS on its terminating read cycle, so this case is expected.
- Write order: any order. Re-writing an entry overwrites its data; the valid bit stays set.
- bank_full[b] = AND of entry_valid[b][*]. It is combinational from the registered bitmap.
- load_done: set the cycle after bank_full becomes all ones; cleared by clr or reset.
- clr:
  - Clears entry_valid, bank_full, load_done and overrun_err.
  - Storage data is preserved.
  - The delay line is not flushed.
- clr and a write completing in the same cycle: clr applies first, then the write sets its valid bit. That write counts toward the new tile.
- Read port: combinational mux. A write at an edge is visible at the outputs after that edge; there is no bypass of same-cycle write data. rd_bank ≥ BANKS returns 0.

## Timing
- Request sampled at edge N → memory data sampled at edge N+MEM_LATENCY, written at that edge.
- Example: the 64th valid write at edge K → bank_full all ones after K, load_done high after K+1.
- Back-to-back requests are sustained at 1 per cycle with no stall.
- Reset values:
  - delay line valid bits 0, entry_valid 0, storage 0
  - bank_full 0, load_done 0, overrun_err 0, weight_out/act_out 0
- Reset mid-load: in-flight responses are discarded. Data returning after reset release is ignored because the tags are invalid.

## Configuration
- OPERAND_LOADER_OVERRUN_CHECK_EN defined:
  - overrun_err sets when a valid write targets an entry whose valid bit is already set.
  - It is sticky until clr or reset.
  - A clr coincident with the write suppresses the error.
- Not defined: overrun_err is tied to 0 and no detection logic is built.

## Structure
- Shared package matmul_pkg holds DATA_WIDTH, BANKS, ENTRIES, BANK_SEL_W, ENTRY_SEL_W, MEM_LATENCY and a packed request-tag typedef (valid, bank, entry).
- Sub-module loader_delay_line: parameterized shift register of request tags.
  - Depth MEM_LATENCY.
  - Asynchronous reset clears the valid bits only.

## Test plan
- Full sequential fill, bank 0 to 7 and entry 0 to 7, with data = {bank, entry} pattern → bank_full = 8'hFF after the final write, load_done high one cycle later, all 64 readbacks match.
- Terminating request with bank_sel = 4'b1000 → no write, no bank_full change, overrun_err stays 0.
- clr pulse coincident with a completing write to (3,5) → afterwards only entry_valid[3][5] is set, load_done = 0, old data still readable at other entries.
- With OPERAND_LOADER_OVERRUN_CHECK_EN: write (2,2) twice → overrun_err = 1, stored data = second value. Without the macro, overrun_err stays 0.
- Reset asserted one cycle after a request burst of 4 → none of the 4 responses are written, all outputs read 0.
- MEM_LATENCY = 3 build, single request at edge 10 → write occurs at edge 13, readback valid from cycle 13 onward.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and the request-tag type for the systolic matmul
// operand fetch path.
package matmul_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int BANKS       = 8;
  localparam int ENTRIES     = 8;
  localparam int BANK_SEL_W  = 4;
  localparam int ENTRY_SEL_W = 3;
  localparam int MEM_LATENCY = 2;

  // One outstanding read request as it travels alongside the memory latency.
  typedef struct packed {
    logic                   valid;
    logic [BANK_SEL_W-1:0]  bank;
    logic [ENTRY_SEL_W-1:0] entry;
  } req_tag_t;

  // A tag only produces a write when it is live and targets a real bank;
  // bank == BANKS is the controller's terminating read and is dropped.
  function automatic logic tag_hits_bank(input req_tag_t t);
    return t.valid && (int'(t.bank) < BANKS);
  endfunction

endpackage

// File: rtl/loader_delay_line.sv
// Fixed-depth shift register that carries request tags so they line up
// with the ROM/RAM read data. Only the valid bits are reset; the bank and
// entry payload is don't-care whenever its valid bit is low.
module loader_delay_line
  import matmul_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY
) (
  input  logic     clk,
  input  logic     reset,
  input  req_tag_t tag_in,
  output req_tag_t tag_out
);

  logic [DEPTH-1:0]       valid_q;
  logic [BANK_SEL_W-1:0]  bank_q  [DEPTH];
  logic [ENTRY_SEL_W-1:0] entry_q [DEPTH];

  // Valid bits shift every cycle and are cleared by reset so in-flight
  // responses are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= tag_in.valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload shifts in lockstep with the valid bits, without reset.
  always_ff @(posedge clk) begin
    bank_q[0]  <= tag_in.bank;
    entry_q[0] <= tag_in.entry;
    for (int i = 1; i < DEPTH; i++) begin
      bank_q[i]  <= bank_q[i-1];
      entry_q[i] <= entry_q[i-1];
    end
  end

  assign tag_out.valid = valid_q[DEPTH-1];
  assign tag_out.bank  = bank_q[DEPTH-1];
  assign tag_out.entry = entry_q[DEPTH-1];

endmodule

// File: rtl/operand_bank_loader.sv
// Operand bank loader: aligns controller read requests with fixed-latency
// ROM (weight) / RAM (activation) data, stores each pair in an
// 8-bank x 8-entry register bank, tracks per-bank fill status and serves
// a combinational read port to the MAC array.
// Optional feature macro: OPERAND_LOADER_OVERRUN_CHECK_EN enables the
// sticky overrun_err detection of re-writes within a tile.
module operand_bank_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
  parameter int BANKS       = matmul_pkg::BANKS,
  parameter int ENTRIES     = matmul_pkg::ENTRIES,
  parameter int BANK_SEL_W  = matmul_pkg::BANK_SEL_W,
  parameter int ENTRY_SEL_W = matmul_pkg::ENTRY_SEL_W,
  parameter int MEM_LATENCY = matmul_pkg::MEM_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [BANK_SEL_W-1:0]  bank_sel,
  input  logic [ENTRY_SEL_W-1:0] entry_sel,
  input  logic [DATA_WIDTH-1:0]  rom_rdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  input  logic                   clr,
  input  logic [BANK_SEL_W-2:0]  rd_bank,
  input  logic [ENTRY_SEL_W-1:0] rd_entry,
  output logic [DATA_WIDTH-1:0]  weight_out,
  output logic [DATA_WIDTH-1:0]  act_out,
  output logic [BANKS-1:0]       bank_full,
  output logic                   load_done,
  output logic                   overrun_err
);

  localparam int BANK_IDX_W = BANK_SEL_W - 1;

  req_tag_t                tag_in;
  req_tag_t                tag_out;
  logic                    wr_en;
  logic [BANK_IDX_W-1:0]   wr_bank;
  logic [ENTRY_SEL_W-1:0]  wr_entry;

  logic [DATA_WIDTH-1:0]   weight_mem  [BANKS][ENTRIES];
  logic [DATA_WIDTH-1:0]   act_mem     [BANKS][ENTRIES];
  logic [ENTRIES-1:0]      entry_valid [BANKS];

  assign tag_in.valid = rd_en;
  assign tag_in.bank  = bank_sel;
  assign tag_in.entry = entry_sel;

  loader_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign wr_en    = tag_hits_bank(tag_out);
  assign wr_bank  = tag_out.bank[BANK_IDX_W-1:0];
  assign wr_entry = tag_out.entry;

  // Capture the returning weight/activation pair; data survives clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          weight_mem[b][e] <= '0;
          act_mem[b][e]    <= '0;
        end
      end
    end else if (wr_en) begin
      weight_mem[wr_bank][wr_entry] <= rom_rdata;
      act_mem[wr_bank][wr_entry]    <= ram_rdata;
    end
  end

  // Fill bitmap: clr wipes it first, then a coincident write re-marks its
  // own entry so that write belongs to the new tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKS; b++) begin
        entry_valid[b] <= '0;
      end
    end else begin
      if (clr) begin
        for (int b = 0; b < BANKS; b++) begin
          entry_valid[b] <= '0;
        end
      end
      if (wr_en) begin
        entry_valid[wr_bank][wr_entry] <= 1'b1;
      end
    end
  end

  // A bank is full once every entry has been written in this tile.
  always_comb begin
    bank_full = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_full[b] = &entry_valid[b];
    end
  end

  // load_done trails the all-full condition by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_done <= 1'b0;
    end else if (clr) begin
      load_done <= 1'b0;
    end else begin
      load_done <= &bank_full;
    end
  end

`ifdef OPERAND_LOADER_OVERRUN_CHECK_EN
  // Sticky flag for a write landing on an entry already filled this tile;
  // a coincident clr means the entry is fresh, so no error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_err <= 1'b0;
    end else if (clr) begin
      overrun_err <= 1'b0;
    end else if (wr_en && entry_valid[wr_bank][wr_entry]) begin
      overrun_err <= 1'b1;
    end
  end
`else
  assign overrun_err = 1'b0;
`endif

  // MAC-side read port; no bypass of a same-cycle write.
  always_comb begin
    weight_out = '0;
    act_out    = '0;
    if (int'(rd_bank) < BANKS) begin
      weight_out = weight_mem[rd_bank][rd_entry];
      act_out    = act_mem[rd_bank][rd_entry];
    end
  end

endmodule
